// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the program counter block.
//   pc_sel_e : next-PC mode select (seq / branch / jal / jalr)
//   state_e  : control FSM states
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JAL  = 2'b10,
    PC_JALR = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-PC target computation.
//   count      : current PC
//   offset     : signed immediate
//   reg_out1   : rs1 value (jalr base)
//   pc_sel     : next-PC mode
//   branch,
//   zero_flag  : branch qualifier / ALU zero
//   target     : next PC (sequential when nothing is taken)
//   take       : non-sequential update requested
//   misaligned : taken target not aligned to PC_STEP
import pc_pkg::*;

module pc_target_calc #(
  parameter int PC_W    = 10,
  parameter int OFF_W   = 21,
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic [PC_W-1:0]  count,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  reg_out1,
  input  logic [1:0]       pc_sel,
  input  logic             branch,
  input  logic             zero_flag,
  output logic [PC_W-1:0]  target,
  output logic             take,
  output logic             misaligned
);

  localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(PC_STEP - 1);

  // Sign-extending to PC_W+1 and truncating to PC_W is the same as taking
  // the low PC_W bits (or sign-extending straight to PC_W if narrower).
  logic [PC_W-1:0] off_pc;

  if (OFF_W >= PC_W) begin : g_off_trunc
    assign off_pc = offset[PC_W-1:0];
    if (OFF_W > PC_W) begin : g_off_hi
      logic unused_off_hi;
      assign unused_off_hi = ^offset[OFF_W-1:PC_W];
    end
  end else begin : g_off_sext
    assign off_pc = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  end

  if (XLEN > PC_W) begin : g_rs1_hi
    logic unused_rs1_hi;
    assign unused_rs1_hi = ^reg_out1[XLEN-1:PC_W];
  end

  logic [PC_W-1:0] seq_t, rel_t, jr_t;

  always_comb begin
    seq_t = count + STEP;
    rel_t = count + off_pc;
    jr_t  = (reg_out1[PC_W-1:0] + off_pc) & ~PC_W'(1);
    target = seq_t;
    take   = 1'b0;
    case (pc_sel_e'(pc_sel))
      PC_BR:   if (branch && zero_flag) begin target = rel_t; take = 1'b1; end
      PC_JAL:  begin target = rel_t; take = 1'b1; end
      PC_JALR: begin target = jr_t;  take = 1'b1; end
      default: ;
    endcase
    misaligned = take && ((target & ALIGN_MASK) != '0);
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter with fetch handshake, stall/halt,
// trap redirect and misaligned-target detection.
//   clk, reset (async, active-low)
//   pc_sel, branch, zero_flag, offset, reg_out1 : next-PC selection inputs
//   stall, halt, trap_req, fetch_ready          : flow control
//   count        : current PC / fetch address
//   link_addr    : count + PC_STEP (combinational)
//   pc_valid     : count is a valid fetch address
//   misalign_err : sticky misaligned-target flag
//   redirect     : one-cycle pulse after a non-sequential update
// Optional: PC_REDIRECT_CNT_EN adds redirect_cnt[15:0], a saturating count
// of redirect pulses (traps included).
import pc_pkg::*;

module pc_unit #(
  parameter int              PC_W     = 10,
  parameter int              OFF_W    = 21,
  parameter int              XLEN     = 32,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC = PC_W'('h3F0)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pc_sel,
  input  logic             branch,
  input  logic             zero_flag,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  reg_out1,
  input  logic             stall,
  input  logic             halt,
  input  logic             trap_req,
  input  logic             fetch_ready,
  output logic [PC_W-1:0]  count,
  output logic [PC_W-1:0]  link_addr,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic             redirect
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [15:0]      redirect_cnt
`endif
);

  state_e          state;
  logic [PC_W-1:0] target;
  logic            take, misaligned, adv;

  pc_target_calc #(
    .PC_W(PC_W), .OFF_W(OFF_W), .XLEN(XLEN), .PC_STEP(PC_STEP)
  ) u_calc (
    .count      (count),
    .offset     (offset),
    .reg_out1   (reg_out1),
    .pc_sel     (pc_sel),
    .branch     (branch),
    .zero_flag  (zero_flag),
    .target     (target),
    .take       (take),
    .misaligned (misaligned)
  );

  assign link_addr = count + PC_W'(PC_STEP);
  assign adv       = fetch_ready && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= RESET_PC;
      state        <= ST_BOOT;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
      redirect     <= 1'b0;
    end else begin
      redirect <= 1'b0;
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          // trap ignores stall/fetch_ready; halt drops any pending jump
          if (trap_req) begin
            count    <= TRAP_VEC;
            redirect <= 1'b1;
          end else if (halt) begin
            state    <= ST_HALT;
            pc_valid <= 1'b0;
          end else if (adv) begin
            if (misaligned) begin
              state        <= ST_ERR;
              pc_valid     <= 1'b0;
              misalign_err <= 1'b1;
            end else begin
              count    <= target;
              redirect <= take;
            end
          end
        end
        ST_HALT: begin
          if (trap_req) begin
            count    <= TRAP_VEC;
            state    <= ST_RUN;
            pc_valid <= 1'b1;
            redirect <= 1'b1;
          end
        end
        ST_ERR: ;  // only reset leaves ERR
        default: ;
      endcase
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      redirect_cnt <= '0;
    else if (redirect && redirect_cnt != 16'hFFFF)
      redirect_cnt <= redirect_cnt + 16'd1;
  end
`endif

endmodule
